// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue/result bundle between the execute stage and muldiv_unit
//
// Purpose: groups the launch request, direct HI/LO writes and the HI/LO/status
// outputs of the multiply/divide engine.
// Signals:
//   start           launch request (sampled only while busy=0)
//   op[1:0]         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a, src_b    rs / rt operands
//   hi_we, lo_we    direct HI / LO write (MTHI / MTLO)
//   wdata           data for hi_we / lo_we
//   busy            operation in flight
//   done            one-cycle pulse, hi/lo carry the new result
//   hi, lo          architectural HI / LO registers
// Modports: master = core side, slave = muldiv_unit side.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, src_a, src_b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU engine owning HI/LO
//
// Purpose: radix-2 shift-add multiplier and restoring divider, one bit per
// cycle over XLEN steps, with sign handling via magnitudes. Writes HI/LO on
// the edge that enters FINISH, so done and the new hi/lo appear together.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset (aborts any operation)
//   bus   muldiv_unit_if.slave: start/op/src_a/src_b, hi_we/lo_we/wdata,
//         busy/done/hi/lo
// Build option: MULDIV_FAST_MULT_EN - when defined, MULT/MULTU finish in one
// cycle using a single full-width multiplier; divide is unchanged.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              is_div;
  logic              neg_q;    // product / quotient must be negated
  logic              neg_r;    // remainder must be negated (dividend sign)
  logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc;      // mult: {partial, multiplier}; div: {rem, dividend/quotient}
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;

  // Operand magnitudes at launch; MULTU/DIVU (op[0]=1) are taken as-is.
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_neg = ~bus.op[0] & bus.src_a[XLEN-1];
  assign b_neg = ~bus.op[0] & bus.src_b[XLEN-1];
  assign a_mag = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag = b_neg ? -bus.src_b : bus.src_b;

`ifdef MULDIV_FAST_MULT_EN
  // Sign/zero-extending to 2*XLEN makes one truncated product correct for both MULT and MULTU.
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{a_neg}}, bus.src_a} * {{XLEN{b_neg}}, bus.src_b};
`endif

  // One iteration step plus the sign-corrected view of its result.
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     sub_diff;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  always_comb begin
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    // Shifted remainder is the top XLEN+1 bits of acc; borrow in the MSB means restore.
    sub_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    if (is_div) begin
      if (!sub_diff[XLEN]) acc_nxt = {sub_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                 acc_nxt = {acc[2*XLEN-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_nxt = {add_sum, acc[XLEN-1:1]};
      else        acc_nxt = {1'b0, acc[2*XLEN-1:1]};
    end
    prod_fix = neg_q ? -acc_nxt : acc_nxt;
    quo_fix  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem_fix  = neg_r ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            is_div <= bus.op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            cnt    <= '0;
            busy_q <= 1'b1;
            // Result assignments below come after the direct writes so they win.
            if (bus.op[1] && (bus.src_b == '0)) begin
              hi_q   <= bus.src_a;
              lo_q   <= '1;
              done_q <= 1'b1;
              state  <= FINISH;
            end
`ifdef MULDIV_FAST_MULT_EN
            else if (!bus.op[1]) begin
              {hi_q, lo_q} <= fast_prod;
              done_q       <= 1'b1;
              state        <= FINISH;
            end
`endif
            else begin
              state <= CALC;
              if (bus.op[1]) begin
                acc  <= {{XLEN{1'b0}}, a_mag};
                opnd <= b_mag;
              end else begin
                acc  <= {{XLEN{1'b0}}, b_mag};
                opnd <= a_mag;
              end
            end
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) begin
            state  <= FINISH;
            done_q <= 1'b1;
            if (is_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        FINISH: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 33;
`endif
  localparam int DLAT = 33;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, m;
    logic [63:0] r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (o)
      2'b00: r = sa * sbv;
      2'b01: r = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) r = {a, 32'hffffffff};
        else begin
          q = sa / sbv;
          m = sa % sbv;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hffffffff};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Scoreboard: every done pulse pops one expected {hi,lo}.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check(e.tag, {bus.hi, bus.lo}, e.val);
      end
    end
  end

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  // Called just after an edge; the following edge (edge 0) samples start.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Caller sits in cycle cur (cycle k = interval after edge k-1).
  task automatic wait_done(input string tag, input int cur, input int lat);
    bit seen;
    int k;
    seen = 1'b0;
    k = cur;
    while (!seen && k <= cur + 60) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        check({tag, "_lat"}, 64'(k), 64'(lat));
        check({tag, "_busy_fin"}, 64'(bus.busy), 64'd1);
      end else begin
        k++;
      end
    end
    if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
    else begin
      @(negedge clk);
      check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
      check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    push(tag, exp);
    launch(o, a, b);
    wait_done(tag, 1, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    int          lat;

    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(posedge clk);
    #1;

    run_op("mult_m3x5",  2'b00, 32'hFFFFFFFD, 32'd5,        {32'hFFFFFFFF, 32'hFFFFFFF1}, MLAT);
    run_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, MLAT);
    run_op("div_m7_2",   2'b10, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, DLAT);
    run_op("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, DLAT);
    run_op("divu_by0",   2'b11, 32'd100,      32'd0,        {32'h00000064, 32'hFFFFFFFF}, 1);
    run_op("div_by0",    2'b10, 32'hFFFFFF00, 32'd0,        {32'hFFFFFF00, 32'hFFFFFFFF}, 1);

    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (i == 0) b = 32'd0;
      lat = o[1] ? ((b == 0) ? 1 : DLAT) : MLAT;
      run_op($sformatf("rand%0d_op%0d", i, o), o, a, b, model(o, a, b), lat);
    end

    // Direct writes in IDLE land the next cycle.
    bus.hi_we = 1'b1; bus.wdata = 32'h5555;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h3333;
    @(negedge clk);
    check("mthi", 64'(bus.hi), 64'h5555);
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    @(negedge clk);
    check("mtlo", 64'(bus.lo), 64'h3333);
    @(posedge clk); #1;

    // start and busy-time hi_we are ignored while an op is in flight.
    push("divu_busy", {32'd6, 32'd142});
    launch(2'b11, 32'd1000, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    bus.op = 2'b00; bus.src_a = 32'd2; bus.src_b = 32'd2; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    @(negedge clk);
    check("busy_hi_we_ignored", 64'(bus.hi), 64'h5555);
    check("busy_mid", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    wait_done("divu_busy", 8, DLAT);
    repeat (5) @(posedge clk);
    #1;

    // Write together with start: applied now, overwritten by the result.
    push("divu_we_start", {32'd1, 32'd7});
    bus.hi_we = 1'b1; bus.wdata = 32'hABCD;
    launch(2'b11, 32'd50, 32'd7);
    bus.hi_we = 1'b0;
    @(negedge clk);
    check("we_with_start", 64'(bus.hi), 64'hABCD);
    @(posedge clk); #1;
    wait_done("divu_we_start", 2, DLAT);

    // Reset mid-operation aborts without a done pulse.
    launch(2'b11, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("abort_idle", 64'(bus.busy), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
